// File: rtl/load_sequencer_pkg.sv
// Shared types for the load sequencer:
// FSM state encoding and source identifiers.
package load_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      WAIT = 2'd2
   } state_e;

   localparam logic SRC_INC = 1'b0;
   localparam logic SRC_DEC = 1'b1;

endpackage

// File: rtl/load_sequencer_if.sv
// Source channels, consumer ack and register-side
// outputs of the load sequencer.
interface load_sequencer_if #(
   parameter int DATA_W = 4
);

   logic              inc_valid;
   logic [DATA_W-1:0] inc_data;
   logic              inc_ready;
   logic              dec_valid;
   logic [DATA_W-1:0] dec_data;
   logic              dec_ready;
   logic              next;
   logic              reg_enable;
   logic [DATA_W-1:0] reg_data;
   logic              reg_src;
   logic              busy;
   logic              timeout;

   modport master (
      output inc_valid, inc_data,
      output dec_valid, dec_data,
      output next,
      input  inc_ready, dec_ready,
      input  reg_enable, reg_data, reg_src,
      input  busy, timeout
   );

   modport slave (
      input  inc_valid, inc_data,
      input  dec_valid, dec_data,
      input  next,
      output inc_ready, dec_ready,
      output reg_enable, reg_data, reg_src,
      output busy, timeout
   );

endinterface

// File: rtl/load_sequencer_rr_arb2.sv
// Two-request round-robin arbiter; the tie-break
// pointer only moves when the grant is consumed.
module rr_arb2
   import load_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       upd,
   output logic [1:0] gnt
);

   // Source that wins when both request
   logic pref_q, pref_d;

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = (pref_q == SRC_DEC) ? 2'b10 : 2'b01;
      end
      pref_d = pref_q;
      if (upd && (gnt != 2'b00)) begin
         pref_d = gnt[0] ? SRC_DEC : SRC_INC;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pref_q <= SRC_INC;
      end else begin
         pref_q <= pref_d;
      end
   end

endmodule

// File: rtl/load_sequencer.sv
// Arbitrates inc/dec sources, strobes the data
// register, then waits for next or a timeout.
module load_sequencer
   import load_seq_pkg::*;
#(
   parameter int DATA_W   = 4,
   parameter int WAIT_MAX = 15
) (
   input logic             clock1,
   input logic             rst_n,
   load_sequencer_if.slave bus
);

   localparam int CNT_W = 8;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(WAIT_MAX - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] reg_data_q, reg_data_d;
   logic              reg_src_q, reg_src_d;
   logic              reg_enable_q, reg_enable_d;
   logic              busy_q, busy_d;
   logic              timeout_q, timeout_d;
   logic [1:0]        gnt;
   logic              idle;
   logic              xfer;

   // Readies must stay low while reset is held
   assign idle = rst_n && (state_q == IDLE);
   assign xfer = idle && (bus.inc_valid || bus.dec_valid);

   rr_arb2 u_arb (
      .clk   (clock1),
      .rst_n (rst_n),
      .req   ({bus.dec_valid, bus.inc_valid}),
      .upd   (xfer),
      .gnt   (gnt)
   );

   assign bus.inc_ready  = idle && gnt[0];
   assign bus.dec_ready  = idle && gnt[1];
   assign bus.reg_enable = reg_enable_q;
   assign bus.reg_data   = reg_data_q;
   assign bus.reg_src    = reg_src_q;
   assign bus.busy       = busy_q;
   assign bus.timeout    = timeout_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      reg_data_d = reg_data_q;
      reg_src_d  = reg_src_q;
      timeout_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (xfer) begin
               state_d    = LOAD;
               reg_src_d  = gnt[1] ? SRC_DEC : SRC_INC;
               reg_data_d = gnt[1] ? bus.dec_data
                                   : bus.inc_data;
            end
         end
         LOAD: begin
            cnt_d   = '0;
            state_d = bus.next ? IDLE : WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // An ack in the final cycle beats the timeout
            if (bus.next) begin
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = IDLE;
               timeout_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      reg_enable_d = (state_d == LOAD);
      busy_d       = (state_d != IDLE);
   end

   always_ff @(posedge clock1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         reg_data_q   <= '0;
         reg_src_q    <= SRC_INC;
         reg_enable_q <= 1'b0;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         reg_data_q   <= reg_data_d;
         reg_src_q    <= reg_src_d;
         reg_enable_q <= reg_enable_d;
         busy_q       <= busy_d;
         timeout_q    <= timeout_d;
      end
   end

endmodule

// File: tb/tb_load_sequencer.sv
// Directed and random stimulus for load_sequencer,
// checked every cycle against a transaction model.
module tb_load_sequencer;

   localparam int WAIT_MAX = 15;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   bit   cmp_en = 1'b0;

   always #5 clk = ~clk;

   load_sequencer_if #(.DATA_W(4)) bus ();

   load_sequencer #(
      .DATA_W   (4),
      .WAIT_MAX (WAIT_MAX)
   ) dut (
      .clock1 (clk),
      .rst_n  (rst_n),
      .bus    (bus)
   );

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h",
                  name, act, exp);
      end
   endtask

   // Model: a transaction lives m_age cycles after its
   // transfer (age 1 = strobe cycle) until acked or
   // it has spent WAIT_MAX cycles waiting.
   bit         m_active = 0;
   bit         m_pref   = 0;
   bit         m_src    = 0;
   bit         m_to     = 0;
   int         m_age    = 0;
   logic [3:0] m_data   = 4'h0;

   initial forever begin
      bit pick;
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_active = 0; m_pref = 0; m_src = 0;
         m_to = 0; m_age = 0; m_data = 4'h0;
      end else begin
         m_to = 0;
         if (m_active) begin
            if (bus.next) m_active = 0;
            else if (m_age == WAIT_MAX + 1) begin
               m_active = 0;
               m_to = 1;
            end else m_age = m_age + 1;
         end else if (bus.inc_valid || bus.dec_valid) begin
            pick = (bus.inc_valid && bus.dec_valid)
                   ? m_pref : bus.dec_valid;
            m_src    = pick;
            m_data   = pick ? bus.dec_data : bus.inc_data;
            m_pref   = !pick;
            m_active = 1;
            m_age    = 1;
         end
      end
   end

   initial forever begin
      logic ei, ed;
      @(negedge clk);
      if (cmp_en) begin
         ei = rst_n && !m_active && bus.inc_valid &&
              (!bus.dec_valid || !m_pref);
         ed = rst_n && !m_active && bus.dec_valid &&
              (!bus.inc_valid || m_pref);
         chk("inc_ready", bus.inc_ready, ei);
         chk("dec_ready", bus.dec_ready, ed);
         chk("busy", bus.busy, m_active);
         chk("reg_enable", bus.reg_enable,
             m_active && m_age == 1);
         chk("timeout", bus.timeout, m_to);
         chk("reg_data", bus.reg_data, m_data);
         chk("reg_src", bus.reg_src, m_src);
      end
   end

   initial begin
      logic [3:0] seq [4];
      int  n, last, tpos, pulses;
      bit  ok, hs_i, hs_d;
      rst_n = 1'b0;
      bus.inc_valid = 1; bus.dec_valid = 1;
      bus.inc_data = 0; bus.dec_data = 0; bus.next = 0;
      repeat (3) @(posedge clk);
      #1 cmp_en = 1'b1;

      // reset held with both valids high
      @(negedge clk); #1;
      chk("rst_readies",
          {bus.inc_ready, bus.dec_ready}, 0);
      chk("rst_outputs", {bus.reg_enable, bus.busy,
          bus.timeout, bus.reg_src, bus.reg_data}, 0);
      rst_n = 1'b1; #1;
      chk("first_grant_inc",
          {bus.inc_ready, bus.dec_ready}, 2'b10);

      // single inc transfer, ack in LOAD
      bus.dec_valid = 0; bus.inc_data = 4'h5;
      @(posedge clk); #1;
      bus.inc_valid = 0; bus.next = 1;
      @(negedge clk);
      chk("single_strobe", {bus.reg_enable,
          bus.reg_src, bus.reg_data}, 6'b10_0101);
      chk("single_busy", bus.busy, 1);
      @(posedge clk); #1;
      bus.next = 0;
      @(negedge clk);
      chk("single_done", {bus.busy, bus.reg_enable,
          bus.reg_data}, 6'b00_0101);

      // contention; last grant was inc, so dec leads
      #1;
      bus.inc_valid = 1; bus.dec_valid = 1;
      bus.inc_data = 4'h3; bus.dec_data = 4'hC;
      bus.next = 1;
      n = 0; last = -1; ok = 1;
      for (int c = 0; c < 20 && n < 4; c++) begin
         @(negedge clk);
         if (bus.reg_enable) begin
            seq[n] = bus.reg_data;
            if (last >= 0 && c - last != 2) ok = 0;
            last = c;
            n++;
         end
      end
      chk("cont_count", n, 4);
      chk("cont_seq",
          {seq[0], seq[1], seq[2], seq[3]}, 16'hC3C3);
      chk("cont_spacing", ok, 1);
      @(posedge clk); #1;
      bus.inc_valid = 0; bus.dec_valid = 0; bus.next = 0;

      // dec transfer, ack 4 cycles after LOAD
      bus.dec_valid = 1; bus.dec_data = 4'h9;
      @(posedge clk); #1;
      bus.dec_valid = 0;
      bus.inc_valid = 1; bus.inc_data = 4'h6;
      ok = 1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (bus.inc_ready || bus.dec_ready ||
             bus.timeout || bus.reg_data != 4'h9) ok = 0;
         @(posedge clk); #1;
      end
      bus.next = 1;
      @(negedge clk);
      if (bus.inc_ready || bus.dec_ready) ok = 0;
      @(posedge clk); #1;
      bus.next = 0;
      @(negedge clk);
      chk("ack_held", ok, 1);
      chk("ack_no_timeout", bus.timeout, 0);
      chk("ack_accept_inc",
          {bus.inc_ready, bus.dec_ready}, 2'b10);

      // inc 6 transfers, never acked -> timeout
      @(posedge clk); #1;
      bus.inc_valid = 0;
      tpos = -1; pulses = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (bus.timeout) begin
            pulses++;
            if (tpos < 0) tpos = k;
         end
      end
      chk("timeout_pos", tpos, 16);
      chk("timeout_pulses", pulses, 1);

      // ack in the last WAIT cycle
      #1;
      bus.inc_valid = 1; bus.inc_data = 4'h7;
      @(posedge clk); #1;
      bus.inc_valid = 0;
      repeat (15) @(posedge clk);
      #1 bus.next = 1;
      @(negedge clk);
      chk("coinc_busy", bus.busy, 1);
      @(posedge clk); #1;
      bus.next = 0;
      @(negedge clk);
      chk("coinc_no_timeout",
          {bus.timeout, bus.busy}, 2'b00);

      // reset two cycles after LOAD of an inc grant
      #1;
      bus.inc_valid = 1; bus.inc_data = 4'hA;
      @(posedge clk); #1;
      bus.inc_valid = 0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("rst_mid_clear", {bus.busy,
          bus.reg_enable, bus.reg_data}, 0);
      bus.inc_valid = 1; bus.dec_valid = 1;
      #1;
      chk("rst_mid_readies",
          {bus.inc_ready, bus.dec_ready}, 0);
      @(negedge clk); #1;
      rst_n = 1'b1; #1;
      chk("rst_mid_pref_inc",
          {bus.inc_ready, bus.dec_ready}, 2'b10);
      bus.inc_valid = 0; bus.dec_valid = 0;

      // random traffic honouring the hold rule
      @(posedge clk); #1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk); #1;
         hs_i = bus.inc_valid && bus.inc_ready;
         hs_d = bus.dec_valid && bus.dec_ready;
         @(posedge clk); #1;
         rst_n = (c != 1500);
         if (!bus.inc_valid || hs_i) begin
            bus.inc_valid = ($urandom_range(0, 2) != 0);
            bus.inc_data  = 4'($urandom);
         end
         if (!bus.dec_valid || hs_d) begin
            bus.dec_valid = ($urandom_range(0, 2) != 0);
            bus.dec_data  = 4'($urandom);
         end
         bus.next = (c < 1500)
                    ? ($urandom_range(0, 3) == 0)
                    : ($urandom_range(0, 12) == 0);
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_sequencer.md
# load_sequencer

Sequencer and arbiter in front of the 4-bit loadable data register on the 250 MHz `clock1` domain. It accepts values from an incremental source and a decremental source over valid/ready channels and picks one per transaction with round-robin arbitration. It issues a single-cycle load strobe to the register, then holds until the downstream consumer acknowledges with `next`, or until a timeout expires.

## Interface
Parameters:
- DATA_W, 4, payload and register width
- WAIT_MAX, 15, cycles to wait for `next` before timing out (1..255)

Ports:
- clock1  in  1  250 MHz clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- inc_valid  in  1  incremental source has data
- inc_data  in  DATA_W  incremental payload
- inc_ready  out  1  incremental transfer accepted this cycle
- dec_valid  in  1  decremental source has data
- dec_data  in  DATA_W  decremental payload
- dec_ready  out  1  decremental transfer accepted this cycle
- next  in  1  consumer has taken the current register value
- reg_enable  out  1  one-cycle load strobe to the register
- reg_data  out  DATA_W  value to load; stable from LOAD until the FSM returns to IDLE
- reg_src  out  1  source of reg_data: 0 = inc, 1 = dec
- busy  out  1  high in every state except IDLE
- timeout  out  1  one-cycle pulse when a WAIT expires

## Operation
- FSM states: IDLE, LOAD, WAIT.
- IDLE:
  - If either valid is high, grant one source.
  - A transfer occurs when valid && ready; ready is combinational and high only in IDLE, only for the granted source.
  - On the transfer, capture payload into reg_data and the source into reg_src, then go to LOAD.
- Arbitration:
  - Single requester wins.
  - Both requesting: the source not granted last wins.
  - After reset, inc has priority.
  - The last-grant pointer updates only on a transfer.
- LOAD:
  - reg_enable = 1 for exactly this cycle.
  - If next = 1 in this cycle, go to IDLE; otherwise go to WAIT and clear the wait counter.
- WAIT:
  - The counter increments each cycle.
  - next = 1 returns to IDLE.
  - If the counter reaches WAIT_MAX-1 without next, pulse timeout for one cycle and go to IDLE.
  - If next and expiry coincide, next wins and no timeout pulse is issued.
- next is ignored in IDLE.
- Valids in LOAD/WAIT are not accepted, since both readies are 0. Sources must hold data while valid and not ready.
- Reset values: state IDLE, reg_enable 0, reg_data 0, reg_src 0, busy 0, timeout 0, pointer = inc preferred, counter 0.
- Reset asserted mid-transaction aborts it immediately. No strobe or timeout is emitted, and no transfer is accepted while rst_n is low.

## Timing
- Transfer at edge T; reg_enable high during cycle T+1. The register loads at the T+2 edge.
- Minimum transaction: 2 cycles (IDLE transfer, LOAD with next). The earliest following transfer is in the IDLE cycle right after.
- Maximum transaction without next: 2 + WAIT_MAX cycles. timeout is high in the last WAIT cycle's successor, together with the return to IDLE.
- reg_enable, busy, timeout, reg_data and reg_src are registered outputs. inc_ready and dec_ready are combinational from state, pointer and valids.

## Structure
- Shared package `load_seq_pkg` holds:
  - state enum (IDLE, LOAD, WAIT)
  - source constants SRC_INC = 1'b0, SRC_DEC = 1'b1
- Sub-module `rr_arb2`: two-request round-robin arbiter with registered last-grant pointer and an update-on-transfer input. It is reused by later multi-source blocks.

## Test plan
- Reset: hold rst_n = 0 with both valids high -> all outputs 0, readies 0. Release -> first grant to inc.
- Single source: inc_valid = 1, inc_data = 4'h5, next pulsed in the LOAD cycle -> reg_enable one cycle with reg_data = 5, reg_src = 0; back in IDLE next cycle; busy high for exactly 1 cycle.
- Contention: both valids held high, inc_data = 3, dec_data = 4'hC, next asserted at each LOAD -> loads alternate 3, C, 3, C; each strobe is 2 cycles apart.
- Delayed ack: dec transfer, next asserted 4 cycles after LOAD -> no timeout; readies stay 0 throughout; next transfer accepted the cycle after return to IDLE.
- Timeout: WAIT_MAX = 15, no next -> timeout pulse 16 cycles after the strobe (15 WAIT cycles); separately, next coincident with expiry -> no pulse.
- Reset mid-WAIT: drop rst_n two cycles after LOAD -> busy and reg_data cleared asynchronously; after release, pointer again prefers inc.
